// File: rtl/ysyx_24120013_pkg.sv
// Shared types and constants for the ysyx_24120013 instruction fetch slice.
// Holds the fetch FSM state encoding, default widths and the boot address.
package ysyx_24120013_pkg;

  localparam int          DEF_ADDR_WIDTH = 32;
  localparam int          DEF_DATA_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC   = 32'h8000_0000;
  localparam int          PERF_WIDTH     = 32;
  localparam int          PC_STEP        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  // Cycles spent waiting on the instruction bus count as fetch stalls.
  function automatic logic is_bus_busy(input ifu_state_e s);
    return (s == REQ) || (s == WAIT);
  endfunction

endpackage

// File: rtl/ysyx_24120013_perf_cnt.sv
// Free-running enable counter used for fetch performance statistics.
// Wraps silently at 2^WIDTH.
module ysyx_24120013_perf_cnt
  import ysyx_24120013_pkg::*;
#(
  parameter int WIDTH = PERF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/ysyx_24120013_ifetch.sv
// Instruction fetch unit: one outstanding bus request, single-entry output hold.
// Define YSYX_24120013_IFU_PERF_EN to build the fetch/stall performance counters.
module ysyx_24120013_ifetch
  import ysyx_24120013_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_jmp_en,
  input  logic [ADDR_WIDTH-1:0] pc_jmp_val,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(PC_STEP);

  ifu_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic                  flush_pend_reg, flush_pend_next;
  logic [ADDR_WIDTH-1:0] flush_pc_reg, flush_pc_next;
  logic [DATA_WIDTH-1:0] inst_reg, inst_next;
  logic [ADDR_WIDTH-1:0] inst_pc_reg, inst_pc_next;
  logic                  inst_fault_reg, inst_fault_next;

  logic                  drop_rsp;
  logic [ADDR_WIDTH-1:0] redir_pc;

  // A redirect arriving in the same cycle as the response still cancels it,
  // and the newest target always wins over an older stored one.
  assign drop_rsp = flush_pend_reg | pc_jmp_en;
  assign redir_pc = pc_jmp_en ? pc_jmp_val : flush_pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      flush_pend_reg <= 1'b0;
      flush_pc_reg   <= RESET_PC;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_fault_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      flush_pend_reg <= flush_pend_next;
      flush_pc_reg   <= flush_pc_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_fault_reg <= inst_fault_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    flush_pend_next = flush_pend_reg;
    flush_pc_next   = flush_pc_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_fault_next = inst_fault_reg;

    case (state_reg)
      IDLE: begin
        state_next = REQ;
        if (pc_jmp_en) begin
          pc_next = pc_jmp_val;
        end
      end

      REQ: begin
        // The request in flight keeps its address; the redirect is deferred.
        if (pc_jmp_en) begin
          flush_pend_next = 1'b1;
          flush_pc_next   = pc_jmp_val;
        end
        if (imem_req_ready) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        if (pc_jmp_en) begin
          flush_pend_next = 1'b1;
          flush_pc_next   = pc_jmp_val;
        end
        if (imem_rsp_valid) begin
          if (drop_rsp) begin
            pc_next         = redir_pc;
            flush_pend_next = 1'b0;
            state_next      = REQ;
          end else begin
            inst_next       = imem_rsp_data;
            inst_fault_next = imem_rsp_err;
            inst_pc_next    = pc_reg;
            state_next      = HOLD;
          end
        end
      end

      HOLD: begin
        // Redirect outranks the sequential step, even on a handshake cycle.
        if (pc_jmp_en) begin
          pc_next    = pc_jmp_val;
          state_next = REQ;
        end else if (inst_ready) begin
          pc_next    = pc_reg + PC_INC;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = pc_reg;
  assign inst_valid     = (state_reg == HOLD) && !flush_pend_reg;
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;
  assign inst_fault     = inst_fault_reg;

`ifdef YSYX_24120013_IFU_PERF_EN
  logic fetch_en;
  logic stall_en;

  assign fetch_en = inst_valid & inst_ready;
  assign stall_en = is_bus_busy(state_reg);

  ysyx_24120013_perf_cnt #(
    .WIDTH (32)
  ) u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .en  (fetch_en),
    .cnt (perf_fetch_cnt)
  );

  ysyx_24120013_perf_cnt #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en),
    .cnt (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_24120013_ifetch.sv
// Self-checking bench for ysyx_24120013_ifetch: directed scenarios plus a randomized
// transaction stream checked against a fetch-stream model (pc sequence and perf totals).
module tb_ysyx_24120013_ifetch;

`ifdef YSYX_24120013_IFU_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        pc_jmp_en;
  logic [31:0] pc_jmp_val;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;

  ysyx_24120013_ifetch #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_jmp_en      (pc_jmp_en),
    .pc_jmp_val     (pc_jmp_val),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one bus transaction from REQ up to the cycle the instruction is presented.
  task automatic do_fetch(input int rdy_wait, input int rsp_wait, input logic [31:0] data,
                          input logic err, output logic [31:0] o_addr, output logic [31:0] o_inst,
                          output logic [31:0] o_pc, output logic o_fault, output int o_lat,
                          output bit o_timeout);
    int guard;
    int t0;
    o_timeout = 1'b0;
    o_addr    = '0;
    o_inst    = '0;
    o_pc      = '0;
    o_fault   = 1'b0;
    o_lat     = 0;
    guard     = 0;
    while (!imem_req_valid && guard < 8) begin
      tick();
      guard++;
    end
    if (!imem_req_valid) begin
      o_timeout = 1'b1;
      return;
    end
    o_addr = imem_req_addr;
    t0     = cyc;
    imem_req_ready = 1'b0;
    repeat (rdy_wait) tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    repeat (rsp_wait) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_rsp_err   = 1'b0;
    guard = 0;
    while (!inst_valid && guard < 8) begin
      tick();
      guard++;
    end
    if (!inst_valid) begin
      o_timeout = 1'b1;
      return;
    end
    o_inst  = inst;
    o_pc    = inst_pc;
    o_fault = inst_fault;
    o_lat   = cyc - t0;
  endtask

  // Accept the presented instruction after hold_wait cycles of backpressure.
  task automatic consume(input int hold_wait, input logic jmp_en, input logic [31:0] jmp_val);
    inst_ready = 1'b0;
    repeat (hold_wait) tick();
    inst_ready = 1'b1;
    pc_jmp_en  = jmp_en;
    pc_jmp_val = jmp_val;
    tick();
    inst_ready = 1'b0;
    pc_jmp_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    n_cmp++; if (inst_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", inst_fault); end
    n_cmp++; if (perf_fetch_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_perf_fetch: got %0d want 0", perf_fetch_cnt); end
    n_cmp++; if (perf_stall_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_perf_stall: got %0d want 0", perf_stall_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL idle_req_valid: got %b want 0", imem_req_valid); end
    tick();
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL first_req_addr: got %h want 80000000", imem_req_addr); end
    exp_pc    = 32'h8000_0000;
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
    $display("reset: first request at %h", imem_req_addr);
  endtask

  task automatic test_sequential();
    logic [31:0] a, d, ins, p;
    logic        f;
    int          lat;
    bit          to;
    int          last_cyc;
    last_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL seq_timeout[%0d]: got %b want 0", k, to); end
      n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL seq_inst_pc[%0d]: got %h want %h", k, p, exp_pc); end
      n_cmp++; if (ins !== d) begin n_bad++; $display("FAIL seq_inst[%0d]: got %h want %h", k, ins, d); end
      n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL seq_fault[%0d]: got %b want 0", k, f); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL seq_latency[%0d]: got %0d want 2", k, lat); end
      if (k > 0) begin
        n_cmp++; if (cyc - last_cyc !== 3) begin n_bad++; $display("FAIL seq_period[%0d]: got %0d want 3", k, cyc - last_cyc); end
      end
      last_cyc  = cyc;
      exp_fetch = exp_fetch + 1;
      exp_stall = exp_stall + 2;
      $display("seq: pc=%h inst=%h lat=%0d", p, ins, lat);
      consume(0, 1'b0, 32'h0);
      exp_pc = exp_pc + 4;
    end
    n_cmp++; if (perf_fetch_cnt !== (PERF_ON ? exp_fetch : 32'd0)) begin n_bad++; $display("FAIL seq_perf_fetch: got %0d want %0d", perf_fetch_cnt, PERF_ON ? exp_fetch : 32'd0); end
    n_cmp++; if (perf_stall_cnt !== (PERF_ON ? exp_stall : 32'd0)) begin n_bad++; $display("FAIL seq_perf_stall: got %0d want %0d", perf_stall_cnt, PERF_ON ? exp_stall : 32'd0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, d, ins, p;
    logic        f;
    int          lat;
    bit          to;
    d = $urandom;
    do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %b want 0", to); end
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", k, inst_valid); end
      n_cmp++; if (inst !== d) begin n_bad++; $display("FAIL bp_inst[%0d]: got %h want %h", k, inst, d); end
      n_cmp++; if (inst_pc !== exp_pc) begin n_bad++; $display("FAIL bp_inst_pc[%0d]: got %h want %h", k, inst_pc, exp_pc); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_valid[%0d]: got %b want 0", k, imem_req_valid); end
      n_cmp++; if (perf_fetch_cnt !== (PERF_ON ? exp_fetch : 32'd0)) begin n_bad++; $display("FAIL bp_perf_fetch[%0d]: got %0d want %0d", k, perf_fetch_cnt, PERF_ON ? exp_fetch : 32'd0); end
      n_cmp++; if (perf_stall_cnt !== (PERF_ON ? exp_stall : 32'd0)) begin n_bad++; $display("FAIL bp_perf_stall[%0d]: got %0d want %0d", k, perf_stall_cnt, PERF_ON ? exp_stall : 32'd0); end
    end
    $display("backpressure: held pc=%h inst=%h for 5 cycles", inst_pc, inst);
    consume(0, 1'b0, 32'h0);
    exp_fetch = exp_fetch + 1;
    exp_pc    = exp_pc + 4;
  endtask

  task automatic test_redirect_wait();
    logic [31:0] a, d, ins, p;
    logic        f;
    int          lat;
    bit          to;
    int          w;
    // Redirect during REQ while the bus stalls; a later one in WAIT must win.
    imem_req_ready = 1'b0;
    pc_jmp_en      = 1'b1;
    pc_jmp_val     = 32'h8000_0300;
    tick();
    pc_jmp_en = 1'b0;
    exp_stall = exp_stall + 1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rdw_req_held: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== exp_pc) begin n_bad++; $display("FAIL rdw_addr_held: got %h want %h", imem_req_addr, exp_pc); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    exp_stall = exp_stall + 1;
    pc_jmp_en  = 1'b1;
    pc_jmp_val = 32'h8000_0100;
    tick();
    pc_jmp_en = 1'b0;
    exp_stall = exp_stall + 1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_valid_a: got %b want 0", inst_valid); end
    w = $urandom_range(0, 2);
    for (int k = 0; k < w; k++) begin
      tick();
      exp_stall = exp_stall + 1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_valid_w[%0d]: got %b want 0", k, inst_valid); end
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom;
    tick();
    imem_rsp_valid = 1'b0;
    exp_stall = exp_stall + 1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rdw_valid_rsp: got %b want 0", inst_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rdw_req_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h8000_0100) begin n_bad++; $display("FAIL rdw_req_addr: got %h want 80000100", imem_req_addr); end
    exp_pc = 32'h8000_0100;
    $display("redirect_wait: response dropped, next addr=%h", imem_req_addr);
    d = $urandom;
    do_fetch(1, 1, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 4;
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rdw_fetch_timeout: got %b want 0", to); end
    n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL rdw_inst_pc: got %h want %h", p, exp_pc); end
    n_cmp++; if (ins !== d) begin n_bad++; $display("FAIL rdw_inst: got %h want %h", ins, d); end
    consume(0, 1'b0, 32'h0);
    exp_fetch = exp_fetch + 1;
    exp_pc    = exp_pc + 4;
  endtask

  task automatic test_simultaneous();
    logic [31:0] a, d, ins, p;
    logic        f;
    int          lat;
    bit          to;
    d = $urandom;
    do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL sim_inst_pc: got %h want %h", p, exp_pc); end
    consume(0, 1'b1, 32'h8000_0200);
    exp_fetch = exp_fetch + 1;
    exp_pc    = 32'h8000_0200;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL sim_req_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== exp_pc) begin n_bad++; $display("FAIL sim_req_addr: got %h want %h", imem_req_addr, exp_pc); end
    n_cmp++; if (perf_fetch_cnt !== (PERF_ON ? exp_fetch : 32'd0)) begin n_bad++; $display("FAIL sim_perf_fetch: got %0d want %0d", perf_fetch_cnt, PERF_ON ? exp_fetch : 32'd0); end
    $display("simultaneous: consumed pc=%h, next addr=%h", p, imem_req_addr);
    d = $urandom;
    do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL sim_next_pc: got %h want %h", p, exp_pc); end
    consume(0, 1'b0, 32'h0);
    exp_fetch = exp_fetch + 1;
    exp_pc    = exp_pc + 4;
  endtask

  task automatic test_fault_wrap();
    logic [31:0] a, d, ins, p;
    logic        f;
    int          lat;
    bit          to;
    d = $urandom;
    do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    consume(0, 1'b1, 32'hFFFF_FFFC);
    exp_fetch = exp_fetch + 1;
    exp_pc    = 32'hFFFF_FFFC;
    d = $urandom;
    do_fetch(0, 0, d, 1'b1, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    n_cmp++; if (a !== exp_pc) begin n_bad++; $display("FAIL fw_req_addr: got %h want %h", a, exp_pc); end
    n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL fw_inst_pc: got %h want %h", p, exp_pc); end
    n_cmp++; if (f !== 1'b1) begin n_bad++; $display("FAIL fw_fault: got %b want 1", f); end
    n_cmp++; if (ins !== d) begin n_bad++; $display("FAIL fw_inst: got %h want %h", ins, d); end
    consume(0, 1'b0, 32'h0);
    exp_fetch = exp_fetch + 1;
    exp_pc    = exp_pc + 4;
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL fw_wrap_addr: got %h want 00000000", imem_req_addr); end
    $display("fault_wrap: faulted pc=%h, next addr=%h", p, imem_req_addr);
    d = $urandom;
    do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    n_cmp++; if (f !== 1'b0) begin n_bad++; $display("FAIL fw_fault_clear: got %b want 0", f); end
    n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL fw_after_pc: got %h want %h", p, exp_pc); end
    consume(0, 1'b0, 32'h0);
    exp_fetch = exp_fetch + 1;
    exp_pc    = exp_pc + 4;
  endtask

  task automatic test_random();
    logic [31:0] a, d, ins, p, tgt;
    logic        f, err, jmp;
    int          lat, rw, sw, hw;
    bit          to;
    for (int k = 0; k < 40; k++) begin
      rw  = $urandom_range(0, 3);
      sw  = $urandom_range(0, 3);
      hw  = $urandom_range(0, 2);
      err = 1'($urandom_range(0, 1));
      jmp = ($urandom_range(0, 3) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      d   = $urandom;
      do_fetch(rw, sw, d, err, a, ins, p, f, lat, to);
      exp_stall = exp_stall + 32'(rw + sw + 2);
      n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rnd_timeout[%0d]: got %b want 0", k, to); end
      n_cmp++; if (a !== exp_pc) begin n_bad++; $display("FAIL rnd_req_addr[%0d]: got %h want %h", k, a, exp_pc); end
      n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL rnd_inst_pc[%0d]: got %h want %h", k, p, exp_pc); end
      n_cmp++; if (ins !== d) begin n_bad++; $display("FAIL rnd_inst[%0d]: got %h want %h", k, ins, d); end
      n_cmp++; if (f !== err) begin n_bad++; $display("FAIL rnd_fault[%0d]: got %b want %b", k, f, err); end
      n_cmp++; if (lat !== rw + sw + 2) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, rw + sw + 2); end
      $display("rnd[%0d]: pc=%h inst=%h fault=%b lat=%0d jmp=%b", k, p, ins, f, lat, jmp);
      consume(hw, jmp, tgt);
      exp_fetch = exp_fetch + 1;
      exp_pc    = jmp ? tgt : exp_pc + 4;
    end
    n_cmp++; if (perf_fetch_cnt !== (PERF_ON ? exp_fetch : 32'd0)) begin n_bad++; $display("FAIL rnd_perf_fetch: got %0d want %0d", perf_fetch_cnt, PERF_ON ? exp_fetch : 32'd0); end
    n_cmp++; if (perf_stall_cnt !== (PERF_ON ? exp_stall : 32'd0)) begin n_bad++; $display("FAIL rnd_perf_stall: got %0d want %0d", perf_stall_cnt, PERF_ON ? exp_stall : 32'd0); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] a, d, ins, p;
    logic        f;
    int          lat;
    bit          to;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rmw_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rmw_inst_valid: got %b want 0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL rmw_inst: got %h want 0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL rmw_inst_pc: got %h want 0", inst_pc); end
    n_cmp++; if (inst_fault !== 1'b0) begin n_bad++; $display("FAIL rmw_fault: got %b want 0", inst_fault); end
    n_cmp++; if (perf_fetch_cnt !== 32'h0) begin n_bad++; $display("FAIL rmw_perf_fetch: got %0d want 0", perf_fetch_cnt); end
    n_cmp++; if (perf_stall_cnt !== 32'h0) begin n_bad++; $display("FAIL rmw_perf_stall: got %0d want 0", perf_stall_cnt); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = $urandom;
    tick();
    rst = 1'b0;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rmw_stale_rsp: got %b want 0", inst_valid); end
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rmw_req_after: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h8000_0000) begin n_bad++; $display("FAIL rmw_req_addr: got %h want 80000000", imem_req_addr); end
    exp_pc    = 32'h8000_0000;
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
    $display("reset_mid_wait: restart addr=%h", imem_req_addr);
    d = $urandom;
    do_fetch(0, 0, d, 1'b0, a, ins, p, f, lat, to);
    exp_stall = exp_stall + 2;
    n_cmp++; if (p !== exp_pc) begin n_bad++; $display("FAIL rmw_inst_pc_after: got %h want %h", p, exp_pc); end
    consume(0, 1'b0, 32'h0);
    exp_fetch = exp_fetch + 1;
    n_cmp++; if (perf_fetch_cnt !== (PERF_ON ? exp_fetch : 32'd0)) begin n_bad++; $display("FAIL rmw_perf_fetch_after: got %0d want %0d", perf_fetch_cnt, PERF_ON ? exp_fetch : 32'd0); end
    n_cmp++; if (perf_stall_cnt !== (PERF_ON ? exp_stall : 32'd0)) begin n_bad++; $display("FAIL rmw_perf_stall_after: got %0d want %0d", perf_stall_cnt, PERF_ON ? exp_stall : 32'd0); end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    cyc            = 0;
    exp_pc         = 32'h8000_0000;
    exp_fetch      = 32'd0;
    exp_stall      = 32'd0;
    rst            = 1'b1;
    pc_jmp_en      = 1'b0;
    pc_jmp_val     = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_simultaneous();
    test_fault_wrap();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
